gpu_cmd_sequencer: RTL

Command front-end for the grayscale GPU core array. It assembles byte-wide opcode halves from the host into 16-bit opcodes and buffers them in a small FIFO. It issues them to the core array as single-cycle `execute` pulses with a programmable minimum spacing, and deserializes the array's serial `valid_bit`/`output_bit` result stream into bytes. It sits between the host pin interface and `core_array`, replacing the free-running two-phase opcode collector with a flow-controlled sequencer.

---
 rtl/gpu_cmd_sequencer_if.sv | 30 +++
 rtl/gpu_cmd_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/gpu_cmd_sequencer_if.sv
// Host/core-array signal bundle for gpu_cmd_sequencer.
// The master modport is the driving side (host and core array model); the sequencer takes the slave modport.
interface gpu_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          flush;
    logic [15:0]   opcode;
    logic          execute;
    logic          core_valid;
    logic          core_bit;
    logic [7:0]    result;
    logic          result_valid;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    modport master (
        output byte_in, byte_valid, flush, core_valid, core_bit,
        input  byte_ready, opcode, execute, result, result_valid, fifo_level, overflow
    );

    modport slave (
        input  byte_in, byte_valid, flush, core_valid, core_bit,
        output byte_ready, opcode, execute, result, result_valid, fifo_level, overflow
    );
endinterface

// File: rtl/gpu_cmd_sequencer.sv
// Opcode assembler + FIFO + spaced issuer + serial result deserializer for the GPU core array.
// Define GPU_SEQ_BYPASS_EN to let an opcode skip the empty FIFO and issue one cycle earlier.
module gpu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    gpu_cmd_sequencer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0] GAP_LAST = 4'(ISSUE_GAP - 1);

    typedef enum logic { ASM_HI, ASM_LO } asm_state_t;
    typedef enum logic { ISS_IDLE, ISS_GAP } iss_state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [7:0]    hold_reg;
    asm_state_t    asm_state_reg;
    iss_state_t    iss_state_reg;
    logic [3:0]    gap_cnt_reg;
    logic [15:0]   opcode_reg;
    logic          execute_reg;
    logic [6:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    result_reg;
    logic          result_valid_reg;
    logic          overflow_reg;

    logic        full, empty, accept, lo_done, bypass, push, pop;
    logic [15:0] word;

    assign full    = (level_reg == LW'(FIFO_DEPTH));
    assign empty   = (level_reg == '0);
    assign accept  = bus.byte_valid && !full && !bus.flush;
    assign lo_done = accept && (asm_state_reg == ASM_LO);
    assign word    = {hold_reg, bus.byte_in};
`ifdef GPU_SEQ_BYPASS_EN
    assign bypass  = lo_done && empty && (iss_state_reg == ISS_IDLE);
`else
    assign bypass  = 1'b0;
`endif
    assign push    = lo_done && !bypass;
    // flush outranks a pending pop so the discarded head never reaches the array
    assign pop     = !bus.flush && (iss_state_reg == ISS_IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            hold_reg         <= '0;
            asm_state_reg    <= ASM_HI;
            iss_state_reg    <= ISS_IDLE;
            gap_cnt_reg      <= '0;
            opcode_reg       <= '0;
            execute_reg      <= 1'b0;
            shift_reg        <= '0;
            bit_cnt_reg      <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            execute_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            if (bus.flush) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                level_reg     <= '0;
                asm_state_reg <= ASM_HI;
                iss_state_reg <= ISS_IDLE;
                gap_cnt_reg   <= '0;
                bit_cnt_reg   <= '0;
                overflow_reg  <= 1'b0;
            end else begin
                if (bus.byte_valid && full)
                    overflow_reg <= 1'b1;
                if (accept) begin
                    if (asm_state_reg == ASM_HI) begin
                        hold_reg      <= bus.byte_in;
                        asm_state_reg <= ASM_LO;
                    end else begin
                        asm_state_reg <= ASM_HI;
                    end
                end
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({push, pop})
                    2'b10:   level_reg <= level_reg + LW'(1);
                    2'b01:   level_reg <= level_reg - LW'(1);
                    default: level_reg <= level_reg;
                endcase

                if (pop || bypass) begin
                    opcode_reg  <= pop ? mem[rd_ptr_reg] : word;
                    execute_reg <= 1'b1;
                    gap_cnt_reg <= '0;
                    if (ISSUE_GAP != 0)
                        iss_state_reg <= ISS_GAP;
                end else if (iss_state_reg == ISS_GAP) begin
                    if (gap_cnt_reg == GAP_LAST)
                        iss_state_reg <= ISS_IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                end

                if (bus.core_valid) begin
                    shift_reg   <= {shift_reg[5:0], bus.core_bit};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        result_reg       <= {shift_reg, bus.core_bit};
                        result_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.byte_ready   = !full;
    assign bus.opcode       = opcode_reg;
    assign bus.execute      = execute_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.fifo_level   = level_reg;
    assign bus.overflow     = overflow_reg;
endmodule
